// File: rtl/mul_scale_pkg.sv
// Shared constants, tag sizing helper and pipeline stage record for the
// multiply-and-scale scheduler.
package mul_scale_pkg;

  localparam int SCALE_MUL   = 1311;
  localparam int SCALE_SHIFT = 19;
  localparam int DW_MAX      = 32;
  localparam int PROD_W      = 2 * DW_MAX;
  localparam int TAG_MAX_W   = 3;

  function automatic int tag_w(input int nreq);
    return (nreq <= 2) ? 1 : $clog2(nreq);
  endfunction

  // One pipeline stage: requester tag and raw 64-bit product ride alongside valid.
  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [PROD_W-1:0]    product;
  } stage_t;

endpackage

// File: rtl/mul_scale_pipe.sv
// Multiply-and-scale datapath. Stage 1 registers the full product; the scaled
// result is formed combinationally from it and lands in the owner's response
// register, which acts as stage 2. No handshake: every accepted op completes.
module mul_scale_pipe
  import mul_scale_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [TAG_MAX_W-1:0] in_tag,
  input  logic [DW-1:0]        dataa,
  input  logic [DW-1:0]        datab,
  output logic                 out_valid,
  output logic [TAG_MAX_W-1:0] out_tag,
  output logic [DW-1:0]        out_data
);

  stage_t            s1;
  logic [PROD_W-1:0] scaled;

  // Stage 1: capture the full-width unsigned product with its tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
    end else begin
      s1.valid   <= in_valid;
      s1.tag     <= in_tag;
      s1.product <= PROD_W'(dataa) * PROD_W'(datab);
    end
  end

  // Scale by 1311 as shift-add, wrapping modulo 2^64, then drop 19 bits.
  always_comb begin
    scaled    = (s1.product << 10) + (s1.product << 8) + (s1.product << 5) - s1.product;
    out_data  = DW'(scaled >> SCALE_SHIFT);
    out_valid = s1.valid;
    out_tag   = s1.tag;
  end

endmodule

// File: rtl/mul_scale_sched.sv
// Round-robin scheduler sharing one multiply-and-scale pipeline among NREQ
// requesters. Each requester holds at most one op between acceptance and
// consumption of its response.
module mul_scale_sched
  import mul_scale_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_dataa,
  input  logic [NREQ*DW-1:0] req_datab,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [NREQ*DW-1:0] rsp_data,
  output logic               busy
);

  localparam int TW = tag_w(NREQ);

  logic [TW-1:0]        ptr;
  logic [TW-1:0]        ptr_next;
  logic [NREQ-1:0]      inflight;
  logic [NREQ-1:0]      eligible;
  logic [NREQ-1:0]      grant;
  logic [TW-1:0]        grant_idx;
  logic                 found;
  int                   idx;
  logic [DW-1:0]        sel_a;
  logic [DW-1:0]        sel_b;
  logic [NREQ-1:0]      res_hit;
  logic                 pipe_valid;
  logic [TAG_MAX_W-1:0] pipe_tag;
  logic [DW-1:0]        pipe_data;

  // Round-robin search from ptr; reset suppresses grants so nothing is accepted and dropped.
  always_comb begin
    eligible  = req_valid & ~(inflight | rsp_valid) & {NREQ{~reset}};
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && eligible[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = TW'(idx);
      end
    end
    ptr_next  = (grant_idx == TW'(NREQ - 1)) ? '0 : grant_idx + TW'(1);
    sel_a     = req_dataa[grant_idx*DW +: DW];
    sel_b     = req_datab[grant_idx*DW +: DW];
    req_ready = grant;
    busy      = (|inflight) | (|rsp_valid);
  end

  // Decode which requester the emerging result belongs to.
  always_comb begin
    res_hit = '0;
    for (int k = 0; k < NREQ; k++) begin
      res_hit[k] = pipe_valid && (pipe_tag == TAG_MAX_W'(k));
    end
  end

  mul_scale_pipe #(.DW(DW)) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (found),
    .in_tag    (TAG_MAX_W'(grant_idx)),
    .dataa     (sel_a),
    .datab     (sel_b),
    .out_valid (pipe_valid),
    .out_tag   (pipe_tag),
    .out_data  (pipe_data)
  );

  // Pointer, credit and response registers; a result and a consume never hit the same slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      inflight  <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      if (found) ptr <= ptr_next;
      for (int k = 0; k < NREQ; k++) begin
        if (grant[k]) inflight[k] <= 1'b1;
        else if (res_hit[k]) inflight[k] <= 1'b0;
        if (res_hit[k]) begin
          rsp_valid[k]          <= 1'b1;
          rsp_data[k*DW +: DW]  <= pipe_data;
        end else if (rsp_ready[k]) begin
          rsp_valid[k] <= 1'b0;
        end
      end
    end
  end

endmodule
